mop_issue_queue: RTL and testbench
==================================

Name: mop_issue_queue

Overview:
- Consumer end of the micro-op cracker interface.
- Accepts one cracked macro-instruction per handshake: a bundle of 0..MAX_MOP_CNT micro-ops plus a count.
- Buffers the micro-ops in a circular queue and issues them one per cycle, in order, to the execute stage over a valid/ready handshake.
- Marks the first and last micro-op of each macro-instruction, and never splits a bundle across an admission decision.

Parameters:
- MAX_MOP_CNT, 6, maximum micro-ops per bundle; must equal the cracker's value.
- MOP_W, 128, width of one packed micro_op_t.
- DEPTH, 16, queue entries; power of two and at least MAX_MOP_CNT.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous queue clear (branch redirect).
- in_valid  in  1  bundle present.
- in_ready  out  1  bundle can be accepted.
- in_cnt  in  3  micro-ops in bundle, 0..MAX_MOP_CNT.
- in_mops  in  MAX_MOP_CNT*MOP_W  bundle; slot 0 in the MSBs, matching the [0:MAX_MOP_CNT-1] packed order.
- out_valid  out  1  out_mop is valid.
- out_ready  in  1  execute stage accepts.
- out_mop  out  MOP_W  head micro-op.
- out_first  out  1  head is the first micro-op of its instruction.
- out_last  out  1  head is the last micro-op of its instruction.
- occupancy  out  $clog2(DEPTH)+1  entries currently held.
- stat_mops  out  32  issued micro-op count (feature).
- stat_insns  out  32  accepted bundle count (feature).
- stat_stall  out  32  cycles with in_valid=1 and in_ready=0 (feature).

Behaviour:
- Reset (reset_n=0, asynchronous): wr_ptr, rd_ptr and occupancy are 0; out_valid=0; out_first=0; out_last=0; stat_* are 0. Storage contents are don't-care. Deasserting reset mid-bundle discards everything.
- Free space: free = DEPTH - occupancy, using the registered occupancy. Dequeues in the same cycle are not credited.
- Admission: in_ready = !flush && (free >= in_cnt). Acceptance is all-or-nothing.
- Enqueue on accept (in_valid && in_ready):
  - Slots 0..in_cnt-1 are written to wr_ptr..wr_ptr+in_cnt-1, modulo DEPTH.
  - Each entry stores a first tag (slot 0) and a last tag (slot in_cnt-1).
  - wr_ptr advances by in_cnt, wrapping modulo DEPTH.
- in_cnt=0 (nop): accepted whenever !flush; no entries are written; counts as one instruction.
- in_cnt > MAX_MOP_CNT is illegal: under simulation, $display an error and $finish; in hardware, treat as 0.
- Dequeue: out_valid = (occupancy != 0).
  - out_mop, out_first and out_last are read combinationally from mem[rd_ptr].
  - On out_valid && out_ready, rd_ptr advances by 1 with wrap.
- Latency: a bundle accepted at edge N presents slot 0 on out_mop after edge N. Issue throughput is one micro-op per cycle.
- Simultaneous enqueue and dequeue: occupancy_next = occupancy + (accepted ? in_cnt : 0) - (dequeued ? 1 : 0).
- Full: occupancy=DEPTH, so in_ready=1 only for in_cnt=0.
- Empty: out_valid=0; out_mop holds a stale value.
- flush=1: takes priority over everything. Pointers and occupancy clear at the next edge; in_ready=0; no dequeue handshake completes that cycle; stat counters are unaffected.
- Ordering: micro-ops leave in exactly the order they entered, with no reordering across bundles.

Optional Feature:
- Macro: MOP_ISSUE_QUEUE_STATS_EN.
- Defined: stat_mops, stat_insns and stat_stall are 32-bit saturating counters, reset to 0 and updated per their port descriptions.
- Undefined: no counter flops; the stat_* ports are tied to 0. All other behaviour is identical.

Test Plan:
- Reset: assert reset_n=0 with clk idle -> out_valid=0, occupancy=0, in_ready=1 for in_cnt=6.
- Single bundle: in_cnt=4 (lea, ld, add, cpy), out_ready=1 -> four consecutive out_valid cycles starting the cycle after accept, in slot order; out_first only on lea; out_last only on cpy; occupancy back to 0.
- Fill/full: out_ready=0; push bundles of 6, 6, then 6 -> third stalls (free=4, in_ready=0, stat_stall increments); push 4 -> accepted, occupancy=16; then in_cnt=1 -> in_ready=0 and in_cnt=0 -> accepted.
- Wrap and concurrency: pre-load 14 entries and issue 10; push 6 while out_ready=1 -> entries wrap past index 15; occupancy goes 4->9; issue order matches push order.
- Flush: with occupancy=7, assert flush together with in_valid and in_cnt=3 -> in_ready=0; next cycle occupancy=0 and out_valid=0; the bundle is dropped.
- Stats (macro defined): accept 3 bundles with cnt 2, 0, 5 and drain -> stat_insns=3, stat_mops=7; macro undefined -> all stat_* stay 0.

Source files
------------

// File: rtl/mop_issue_queue.sv
// In-order micro-op issue queue fed by the cracker, one bundle per handshake, one micro-op per cycle out.
// Optional statistics counters are enabled by defining MOP_ISSUE_QUEUE_STATS_EN.
module mop_issue_queue #(
    parameter int unsigned MAX_MOP_CNT = 6,
    parameter int unsigned MOP_W       = 128,
    parameter int unsigned DEPTH       = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [2:0]                   in_cnt,
    input  logic [MAX_MOP_CNT*MOP_W-1:0] in_mops,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [MOP_W-1:0]             out_mop,
    output logic                         out_first,
    output logic                         out_last,
    output logic [$clog2(DEPTH):0]       occupancy,
    output logic [31:0]                  stat_mops,
    output logic [31:0]                  stat_insns,
    output logic [31:0]                  stat_stall
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam int unsigned CNT_W = 3;

    typedef struct packed {
        logic [MOP_W-1:0] mop;
        logic             first;
        logic             last;
    } entry_t;

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_q, wr_d;
    logic [PTR_W-1:0]   rd_q, rd_d;
    logic [OCC_W-1:0]   occ_q, occ_d;

    logic [CNT_W-1:0]   cnt_c;
    logic [OCC_W-1:0]   free_c;
    logic               accept_c;
    logic               deq_c;
    logic [PTR_W-1:0]   widx_c [MAX_MOP_CNT];

    // Out-of-range counts behave as a nop bundle.
    always_comb begin
        cnt_c = in_cnt;
        if (in_cnt > CNT_W'(MAX_MOP_CNT)) begin
            cnt_c = '0;
        end
    end

    // Admission uses registered occupancy only; same-cycle dequeues do not free space.
    assign free_c    = OCC_W'(DEPTH) - occ_q;
    assign in_ready  = !flush && (free_c >= OCC_W'(cnt_c));
    assign accept_c  = in_valid && in_ready;
    assign out_valid = (occ_q != '0);
    assign deq_c     = out_valid && out_ready && !flush;

    always_comb begin
        for (int unsigned s = 0; s < MAX_MOP_CNT; s++) begin
            widx_c[s] = wr_q + PTR_W'(s);
        end
    end

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        occ_d = occ_q;
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            occ_d = '0;
        end else begin
            if (accept_c) begin
                wr_d = wr_q + PTR_W'(cnt_c);
            end
            if (deq_c) begin
                rd_d = rd_q + PTR_W'(1);
            end
            occ_d = occ_q + (accept_c ? OCC_W'(cnt_c) : OCC_W'(0))
                          - (deq_c ? OCC_W'(1) : OCC_W'(0));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            occ_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            occ_q <= occ_d;
        end
    end

    // Storage needs no reset; slot 0 of the bundle sits in the MSBs of in_mops.
    always_ff @(posedge clk) begin
        if (accept_c) begin
            for (int unsigned s = 0; s < MAX_MOP_CNT; s++) begin
                if (CNT_W'(s) < cnt_c) begin
                    mem_q[widx_c[s]].mop   <= in_mops[(MAX_MOP_CNT-1-s)*MOP_W +: MOP_W];
                    mem_q[widx_c[s]].first <= (s == 0);
                    mem_q[widx_c[s]].last  <= (CNT_W'(s) == cnt_c - CNT_W'(1));
                end
            end
        end
    end

    assign out_mop   = mem_q[rd_q].mop;
    assign out_first = out_valid && mem_q[rd_q].first;
    assign out_last  = out_valid && mem_q[rd_q].last;
    assign occupancy = occ_q;

`ifdef MOP_ISSUE_QUEUE_STATS_EN
    logic [31:0] stat_mops_q, stat_insns_q, stat_stall_q;

    // Saturating event counters; flush does not clear them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_mops_q  <= '0;
            stat_insns_q <= '0;
            stat_stall_q <= '0;
        end else begin
            if (deq_c && (stat_mops_q != '1)) begin
                stat_mops_q <= stat_mops_q + 32'd1;
            end
            if (accept_c && (stat_insns_q != '1)) begin
                stat_insns_q <= stat_insns_q + 32'd1;
            end
            if (in_valid && !in_ready && (stat_stall_q != '1)) begin
                stat_stall_q <= stat_stall_q + 32'd1;
            end
        end
    end

    assign stat_mops  = stat_mops_q;
    assign stat_insns = stat_insns_q;
    assign stat_stall = stat_stall_q;
`else
    assign stat_mops  = '0;
    assign stat_insns = '0;
    assign stat_stall = '0;
`endif

`ifndef SYNTHESIS
    // Catch an illegal bundle count from the cracker during simulation.
    always @(posedge clk) begin
        if (reset_n && in_valid && (in_cnt > CNT_W'(MAX_MOP_CNT))) begin
            $error("mop_issue_queue: illegal in_cnt %0d", in_cnt);
            $finish;
        end
    end
`endif

endmodule

// File: tb/tb_mop_issue_queue.sv
// Directed self-checking bench for mop_issue_queue; a scoreboard queue holds the expected issue order.
module tb_mop_issue_queue;

    localparam int unsigned MAXC  = 6;
    localparam int unsigned MW    = 128;
    localparam int unsigned DEPTH = 16;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_cnt;
    logic [MAXC*MW-1:0] in_mops;
    logic              out_valid;
    logic              out_ready;
    logic [MW-1:0]     out_mop;
    logic              out_first;
    logic              out_last;
    logic [4:0]        occupancy;
    logic [31:0]       stat_mops;
    logic [31:0]       stat_insns;
    logic [31:0]       stat_stall;

    mop_issue_queue #(.MAX_MOP_CNT(MAXC), .MOP_W(MW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_cnt     (in_cnt),
        .in_mops    (in_mops),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_mop    (out_mop),
        .out_first  (out_first),
        .out_last   (out_last),
        .occupancy  (occupancy),
        .stat_mops  (stat_mops),
        .stat_insns (stat_insns),
        .stat_stall (stat_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [MW-1:0] mop;
        logic          first;
        logic          last;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_mops = 0;
    int   exp_insns = 0;
    int   exp_stall = 0;

    function automatic logic [MW-1:0] mk(input int id);
        return {96'hA5A5_0000_0000_0000_0000_0000, 32'(id)};
    endfunction

    task automatic chk(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one bundle for one cycle; exp_acc is the hand-derived admission result.
    task automatic push(input int base, input int cnt, input bit exp_acc);
        in_valid = 1'b1;
        in_cnt   = 3'(cnt);
        for (int s = 0; s < int'(MAXC); s++) begin
            in_mops[(int'(MAXC)-1-s)*int'(MW) +: MW] = (s < cnt) ? mk(base + s) : {8{16'hDEAD}};
        end
        #1;
        chk("in_ready", MW'(in_ready), MW'(exp_acc));
        if (exp_acc) begin
            exp_insns++;
            for (int s = 0; s < cnt; s++) begin
                sb.push_back('{mop: mk(base + s), first: (s == 0), last: (s == cnt - 1)});
            end
        end else begin
            exp_stall++;
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic check_head(input string tag);
        exp_t e;
        e = sb.pop_front();
        chk({tag, "_valid"}, MW'(out_valid), MW'(1));
        chk({tag, "_mop"},   out_mop,         e.mop);
        chk({tag, "_first"}, MW'(out_first), MW'(e.first));
        chk({tag, "_last"},  MW'(out_last),  MW'(e.last));
    endtask

    task automatic drain(input int n);
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            #1;
            check_head("drain");
            exp_mops++;
            tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic check_stats(input string tag);
`ifdef MOP_ISSUE_QUEUE_STATS_EN
        chk({tag, "_stat_mops"},  MW'(stat_mops),  MW'(32'(exp_mops)));
        chk({tag, "_stat_insns"}, MW'(stat_insns), MW'(32'(exp_insns)));
        chk({tag, "_stat_stall"}, MW'(stat_stall), MW'(32'(exp_stall)));
`else
        chk({tag, "_stat_mops"},  MW'(stat_mops),  MW'(0));
        chk({tag, "_stat_insns"}, MW'(stat_insns), MW'(0));
        chk({tag, "_stat_stall"}, MW'(stat_stall), MW'(0));
`endif
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int i_before;
        int m_before;

        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_cnt    = 3'd6;
        in_mops   = '0;
        out_ready = 1'b0;

        // Reset state, sampled before the first clock edge
        #2;
        chk("rst_out_valid", MW'(out_valid), MW'(0));
        chk("rst_occupancy", MW'(occupancy), MW'(0));
        chk("rst_in_ready6", MW'(in_ready),  MW'(1));
        chk("rst_out_first", MW'(out_first), MW'(0));
        chk("rst_out_last",  MW'(out_last),  MW'(0));
        check_stats("rst");
        #10;
        reset_n = 1'b1;
        tick();

        // Single 4-op bundle: lea, ld, add, cpy
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_cnt    = 3'd4;
        in_mops   = {mk(32'h1EA), mk(32'h1D), mk(32'hADD), mk(32'hC9), {2{mk(32'hDEAD)}}};
        #1;
        chk("single_in_ready", MW'(in_ready), MW'(1));
        exp_insns++;
        sb.push_back('{mop: mk(32'h1EA), first: 1'b1, last: 1'b0});
        sb.push_back('{mop: mk(32'h1D),  first: 1'b0, last: 1'b0});
        sb.push_back('{mop: mk(32'hADD), first: 1'b0, last: 1'b0});
        sb.push_back('{mop: mk(32'hC9),  first: 1'b0, last: 1'b1});
        tick();
        in_valid = 1'b0;
        chk("single_occ", MW'(occupancy), MW'(4));
        drain(4);
        chk("single_empty_occ",   MW'(occupancy), MW'(0));
        chk("single_empty_valid", MW'(out_valid), MW'(0));

        // Fill to full with out_ready low
        push(32'h100, 6, 1'b1);
        chk("fill_occ6", MW'(occupancy), MW'(6));
        push(32'h110, 6, 1'b1);
        chk("fill_occ12", MW'(occupancy), MW'(12));
        push(32'h200, 6, 1'b0);
        chk("fill_stall_occ", MW'(occupancy), MW'(12));
        check_stats("fill_stall");
        push(32'h120, 4, 1'b1);
        chk("fill_occ16", MW'(occupancy), MW'(16));
        in_valid = 1'b1;
        in_cnt   = 3'd1;
        #1;
        chk("full_cnt1_ready", MW'(in_ready), MW'(0));
        push(0, 0, 1'b1);
        chk("full_nop_occ", MW'(occupancy), MW'(16));
        drain(16);
        chk("fill_drained_occ", MW'(occupancy), MW'(0));

        // Wrap past the last entry with concurrent enqueue and dequeue
        push(32'h300, 6, 1'b1);
        push(32'h310, 6, 1'b1);
        push(32'h320, 2, 1'b1);
        chk("wrap_occ14", MW'(occupancy), MW'(14));
        drain(10);
        chk("wrap_occ4", MW'(occupancy), MW'(4));
        out_ready = 1'b1;
        #1;
        check_head("wrap_concurrent");
        exp_mops++;
        push(32'h330, 6, 1'b1);
        chk("wrap_occ9", MW'(occupancy), MW'(9));
        drain(9);
        chk("wrap_drained_occ", MW'(occupancy), MW'(0));

        // Flush with a bundle offered in the same cycle
        push(32'h400, 6, 1'b1);
        push(32'h410, 1, 1'b1);
        chk("flush_pre_occ", MW'(occupancy), MW'(7));
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_cnt    = 3'd3;
        out_ready = 1'b1;
        #1;
        chk("flush_in_ready", MW'(in_ready), MW'(0));
        exp_stall++;
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("flush_occ",   MW'(occupancy), MW'(0));
        chk("flush_valid", MW'(out_valid), MW'(0));
        sb.delete();
        check_stats("flush");
        push(32'h500, 2, 1'b1);
        drain(2);

        // Statistics over bundles of 2, 0 and 5
        i_before = exp_insns;
        m_before = exp_mops;
        push(32'h600, 2, 1'b1);
        push(0, 0, 1'b1);
        push(32'h610, 5, 1'b1);
        drain(7);
        chk("stats_delta_insns", MW'(exp_insns - i_before), MW'(3));
        chk("stats_delta_mops",  MW'(exp_mops - m_before),  MW'(7));
        check_stats("final");
        chk("final_occ", MW'(occupancy), MW'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
